// File: rtl/rs_ex_pkg.sv
// Shared encodings and types for the execute stage: opnum codes, operand widths,
// ROB tag sentinel and the ALU result bundle.
package rs_ex_pkg;
  localparam int OPNUM_W  = 6;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int ROB_ID_W = 5;

  // 16-entry ROB; the extra tag bit marks "no tag".
  localparam logic [ROB_ID_W-1:0] INVALID_ROB = 5'd16;
  localparam logic [DATA_W-1:0]   NULL_DATA   = '0;

  typedef enum logic [OPNUM_W-1:0] {
    OP_NULL  = 6'd0,
    OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
    OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14,
    OP_LHU   = 6'd15, OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18,
    OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22,
    OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
    OP_OR    = 6'd36, OP_AND   = 6'd37
  } opnum_e;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic              jump;
    logic [ADDR_W-1:0] target;
  } ex_res_t;
endpackage

// File: rtl/rs_ex_alu.sv
// Combinational integer ALU and branch resolver; vld is low for ops this unit
// does not execute (null, loads/stores, unknown codes).
module rs_ex_alu
  import rs_ex_pkg::*;
(
  input  logic [OPNUM_W-1:0] opnum_i,
  input  logic [DATA_W-1:0]  v1_i,
  input  logic [DATA_W-1:0]  v2_i,
  input  logic [DATA_W-1:0]  pc_i,
  input  logic [DATA_W-1:0]  imm_i,
  output ex_res_t            res_o
);
  logic [DATA_W-1:0] pc4, pc_imm, v1_imm;
  logic              take;

  assign pc4    = pc_i + 32'd4;
  assign pc_imm = pc_i + imm_i;
  assign v1_imm = v1_i + imm_i;

  always_comb begin
    unique case (opnum_i)
      OP_BEQ:  take = (v1_i == v2_i);
      OP_BNE:  take = (v1_i != v2_i);
      OP_BLT:  take = ($signed(v1_i) <  $signed(v2_i));
      OP_BGE:  take = ($signed(v1_i) >= $signed(v2_i));
      OP_BLTU: take = (v1_i <  v2_i);
      OP_BGEU: take = (v1_i >= v2_i);
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    res_o.vld    = 1'b1;
    res_o.data   = NULL_DATA;
    res_o.jump   = 1'b0;
    res_o.target = pc4;
    case (opnum_i)
      OP_LUI:   res_o.data = imm_i;
      OP_AUIPC: res_o.data = pc_imm;
      OP_JAL: begin
        res_o.data = pc4; res_o.jump = 1'b1; res_o.target = pc_imm;
      end
      OP_JALR: begin
        res_o.data = pc4; res_o.jump = 1'b1; res_o.target = {v1_imm[DATA_W-1:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        res_o.jump = take;
        if (take) res_o.target = pc_imm;
      end
      OP_ADDI:  res_o.data = v1_imm;
      OP_SLTI:  res_o.data = {31'b0, $signed(v1_i) < $signed(imm_i)};
      OP_SLTIU: res_o.data = {31'b0, v1_i < imm_i};
      OP_XORI:  res_o.data = v1_i ^ imm_i;
      OP_ORI:   res_o.data = v1_i | imm_i;
      OP_ANDI:  res_o.data = v1_i & imm_i;
      OP_SLLI:  res_o.data = v1_i << imm_i[4:0];
      OP_SRLI:  res_o.data = v1_i >> imm_i[4:0];
      OP_SRAI:  res_o.data = $signed(v1_i) >>> imm_i[4:0];
      OP_ADD:   res_o.data = v1_i + v2_i;
      OP_SUB:   res_o.data = v1_i - v2_i;
      OP_SLL:   res_o.data = v1_i << v2_i[4:0];
      OP_SLT:   res_o.data = {31'b0, $signed(v1_i) < $signed(v2_i)};
      OP_SLTU:  res_o.data = {31'b0, v1_i < v2_i};
      OP_XOR:   res_o.data = v1_i ^ v2_i;
      OP_SRL:   res_o.data = v1_i >> v2_i[4:0];
      OP_SRA:   res_o.data = $signed(v1_i) >>> v2_i[4:0];
      OP_OR:    res_o.data = v1_i | v2_i;
      OP_AND:   res_o.data = v1_i & v2_i;
      default: begin
        res_o.vld    = 1'b0;
        res_o.target = NULL_DATA;
      end
    endcase
  end
endmodule

// File: rtl/rs_ex.sv
// Execute stage: one register stage behind the ALU that broadcasts the result
// and resolved control flow for a single cycle.
module rs_ex
  import rs_ex_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback_sign_from_rob,
  input  logic [OPNUM_W-1:0]  opnum_from_rs,
  input  logic [DATA_W-1:0]   V1_from_rs,
  input  logic [DATA_W-1:0]   V2_from_rs,
  input  logic [DATA_W-1:0]   pc_from_rs,
  input  logic [DATA_W-1:0]   imm_from_rs,
  input  logic [ROB_ID_W-1:0] rob_id_from_rs,
  output logic                valid_sign,
  output logic [ROB_ID_W-1:0] rob_id,
  output logic [DATA_W-1:0]   data,
  output logic                jump_sign_to_rob,
  output logic [ADDR_W-1:0]   target_pc_to_rob
);
  ex_res_t             alu_res;
  ex_res_t             res_d, res_q;
  logic [ROB_ID_W-1:0] rob_d, rob_q;

  rs_ex_alu alu (
    .opnum_i (opnum_from_rs),
    .v1_i    (V1_from_rs),
    .v2_i    (V2_from_rs),
    .pc_i    (pc_from_rs),
    .imm_i   (imm_from_rs),
    .res_o   (alu_res)
  );

  // Flush wins over issue; a killed or non-ALU op leaves the stage idle.
  always_comb begin
    res_d = '0;
    rob_d = INVALID_ROB;
    if (!rollback_sign_from_rob && alu_res.vld) begin
      res_d = alu_res;
      rob_d = rob_id_from_rs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      rob_q <= INVALID_ROB;
    end else if (rdy) begin
      res_q <= res_d;
      rob_q <= rob_d;
    end
  end

  assign valid_sign       = res_q.vld;
  assign rob_id           = rob_q;
  assign data             = res_q.data;
  assign jump_sign_to_rob = res_q.jump;
  assign target_pc_to_rob = res_q.target;
endmodule
